ps2_mouse_tracker: RTL and testbench
====================================

Name: ps2_mouse_tracker

Overview:
- Producer side of the mouse interface consumed by the rectangle controller.
- Receives raw PS/2 mouse frames and assembles standard 3-byte movement packets.
- Integrates the signed deltas into an absolute on-screen cursor position, clamped to the visible area.
- Outputs mouse_x_position, mouse_y_position and mouse_left for the drawing/control pipeline.

Parameters:
MAX_X, 800, visible width; X clamps to 0..MAX_X-1
MAX_Y, 600, visible height; Y clamps to 0..MAX_Y-1
INIT_X, 0, X value after reset
INIT_Y, 0, Y value after reset
TIMEOUT_CYCLES, 65000, clk cycles with no ps2_clk falling edge mid-frame before the frame is aborted

Ports:
clk  input  1  system clock (pixel clock domain)
rst  input  1  asynchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock line, asynchronous
ps2_data  input  1  raw PS/2 data line, asynchronous
mouse_x_position  output  12  absolute X, 0..MAX_X-1
mouse_y_position  output  12  absolute Y, 0..MAX_Y-1, screen-down positive
mouse_left  output  1  left button state from last valid packet
mouse_right  output  1  right button state from last valid packet
packet_valid  output  1  one-cycle pulse when outputs update
frame_err  output  1  one-cycle pulse on parity/start/stop error or timeout

Behaviour:
- Reset (async assert, sync release): mouse_x_position=INIT_X, mouse_y_position=INIT_Y. All other outputs 0. Byte index 0, bit FSM IDLE, sync FFs to 1.
- Sync: ps2_clk and ps2_data each pass through 2 FFs. The falling-edge strobe is registered from the synced ps2_clk. Data is sampled on that strobe.
- Bit FSM (11-bit frame, states IDLE, DATA, PARITY, STOP):
  - IDLE: waits for a strobe with data=0 (start). A strobe with data=1 in IDLE is ignored.
  - DATA: shifts 8 bits, LSB first, then moves to PARITY.
  - PARITY: sampled bit must give odd parity over data+parity.
  - STOP: sampled bit must be 1. The FSM then returns to IDLE and delivers the byte.
- Error handling: a parity or stop error pulses frame_err, discards the byte, and resets the byte index to 0.
- Timeout: counter clears on every strobe and counts only while not in IDLE. Reaching TIMEOUT_CYCLES-1 pulses frame_err, returns to IDLE, and sets byte index to 0.
- Packet assembly:
  - Byte 0 is accepted only if bit3=1. Otherwise it is dropped (no frame_err) and the index stays 0 for resync.
  - Bytes 1 and 2 are stored as X and Y deltas.
  - Byte 0 fields: bit0 left, bit1 right, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
- Update: on the clk after byte 2's stop bit is sampled, all outputs update together and packet_valid=1 for exactly that cycle.
- Arithmetic:
  - dx={Xsign,byte1} and dy={Ysign,byte2} are 9-bit two's complement.
  - If an axis overflow bit is set, that axis delta is treated as 0. The buttons still update.
  - nx = x+dx and ny = y-dy, computed as 14-bit signed (PS/2 Y is up-positive).
  - Clamp: <0 gives 0; >MAX_X-1 gives MAX_X-1 (likewise MAX_Y-1).
- Hold: buttons and positions hold between packets. A partial or erroneous packet never changes outputs.
- Reset mid-frame: immediate abort, no pulses.
- frame_err and packet_valid never assert in the same cycle.

Test Plan:
1. Reset with INIT_X=400, INIT_Y=300 → outputs 400/300/0/0. Send packet 0x09,0x0A,0x05 → one packet_valid pulse; X=410, Y=295, left=1, right=0.
2. From X=5, Y=590 send 0x38,0xF0,0xE0 (dx=-16, dy=-32) → X clamps to 0, Y clamps to 599.
3. Byte 0 with a wrong parity bit → frame_err pulse; a following good 3-byte packet still decodes and updates correctly.
4. Stream 0x02 (bit3=0), then good packet 0x0A,0x01,0x00 → first byte silently dropped; X+1, right=1, packet_valid pulses once.
5. Stop clocking after 4 data bits for TIMEOUT_CYCLES → frame_err after exactly TIMEOUT_CYCLES idle cycles. The next full packet is accepted with no stale bits.
6. Packet 0x49,0xFF,0x03 (X overflow) → X unchanged, Y-=3, left=1. Assert rst mid-byte → outputs return to INIT values immediately, no packet_valid.

Source files
------------

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse receiver: synchronises the raw PS/2 lines, deframes 11-bit
// frames, assembles 3-byte movement packets and integrates the deltas into
// a clamped absolute cursor position with button state.
module ps2_mouse_tracker #(
  parameter int MAX_X          = 800,
  parameter int MAX_Y          = 600,
  parameter int INIT_X         = 0,
  parameter int INIT_Y         = 0,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [11:0] mouse_x_position,
  output logic [11:0] mouse_y_position,
  output logic        mouse_left,
  output logic        mouse_right,
  output logic        packet_valid,
  output logic        frame_err
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} bit_state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic signed [13:0] X_LIM = 14'(MAX_X - 1);
  localparam logic signed [13:0] Y_LIM = 14'(MAX_Y - 1);

  logic clk_s1, clk_s2, data_s1, data_s2, clk_prev;
  logic strobe, data_bit;

  bit_state_t state_q, state_d;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt;
  logic          parity_q;
  logic [TW-1:0] tmo_cnt;
  logic          timeout_hit, byte_done, bit_err;

  logic [1:0] byte_idx;
  logic [5:0] hdr_q;   // {y_ovf, x_ovf, y_sign, x_sign, right, left}
  logic [7:0] dx_byte_q;

  logic signed [13:0] dx, dy, nx, ny;
  logic [11:0] x_clamped, y_clamped;

  // Two-flop synchronisers plus a registered falling-edge strobe with its data bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      clk_prev <= 1'b1;
      strobe   <= 1'b0;
      data_bit <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
      clk_prev <= clk_s2;
      strobe   <= clk_prev & ~clk_s2;
      data_bit <= data_s2;
    end
  end

  // Frame watchdog: cleared by every strobe, runs only while a frame is open
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (strobe || state_q == IDLE) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_LAST) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign timeout_hit = (state_q != IDLE) && !strobe && (tmo_cnt == TMO_LAST);

  // Bit FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Bit FSM next state; a byte is delivered or rejected at the stop bit
  always_comb begin
    state_d   = state_q;
    byte_done = 1'b0;
    bit_err   = 1'b0;
    if (timeout_hit) begin
      state_d = IDLE;
    end else if (strobe) begin
      case (state_q)
        IDLE:   if (!data_bit) state_d = DATA;
        DATA:   if (bit_cnt == 3'd7) state_d = PARITY;
        PARITY: state_d = STOP;
        STOP: begin
          state_d = IDLE;
          if (data_bit && (^{shift_q, parity_q})) byte_done = 1'b1;
          else                                    bit_err   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Shift register, bit counter and captured parity bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      parity_q <= 1'b0;
    end else if (strobe) begin
      case (state_q)
        IDLE:   bit_cnt <= '0;
        DATA: begin
          shift_q <= {data_bit, shift_q[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        PARITY: parity_q <= data_bit;
        default: ;
      endcase
    end
  end

  // Position arithmetic: sign-extend deltas, zero them on overflow, clamp
  always_comb begin
    dx = hdr_q[4] ? 14'sd0 : {{5{hdr_q[2]}}, hdr_q[2], dx_byte_q};
    dy = hdr_q[5] ? 14'sd0 : {{5{hdr_q[3]}}, hdr_q[3], shift_q};
    nx = $signed({2'b00, mouse_x_position}) + dx;
    ny = $signed({2'b00, mouse_y_position}) - dy;
    if (nx < 14'sd0)      x_clamped = 12'd0;
    else if (nx > X_LIM)  x_clamped = X_LIM[11:0];
    else                  x_clamped = nx[11:0];
    if (ny < 14'sd0)      y_clamped = 12'd0;
    else if (ny > Y_LIM)  y_clamped = Y_LIM[11:0];
    else                  y_clamped = ny[11:0];
  end

  // Packet assembly and output update; errors restart assembly at byte 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx         <= 2'd0;
      hdr_q            <= '0;
      dx_byte_q        <= '0;
      mouse_x_position <= 12'(INIT_X);
      mouse_y_position <= 12'(INIT_Y);
      mouse_left       <= 1'b0;
      mouse_right      <= 1'b0;
      packet_valid     <= 1'b0;
      frame_err        <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (bit_err || timeout_hit) begin
        frame_err <= 1'b1;
        byte_idx  <= 2'd0;
      end else if (byte_done) begin
        case (byte_idx)
          2'd0: if (shift_q[3]) begin
            hdr_q    <= {shift_q[7:4], shift_q[1:0]};
            byte_idx <= 2'd1;
          end
          2'd1: begin
            dx_byte_q <= shift_q;
            byte_idx  <= 2'd2;
          end
          default: begin
            mouse_x_position <= x_clamped;
            mouse_y_position <= y_clamped;
            mouse_left       <= hdr_q[0];
            mouse_right      <= hdr_q[1];
            packet_valid     <= 1'b1;
            byte_idx         <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Self-checking bench for ps2_mouse_tracker: hand-computed packet table,
// randomized packets against an integer reference model, timeout and
// mid-frame reset sequences.
module tb_ps2_mouse_tracker;

  localparam int MAX_X   = 800;
  localparam int MAX_Y   = 600;
  localparam int INIT_X  = 400;
  localparam int INIT_Y  = 300;
  localparam int TIMEOUT = 300;
  localparam int HALF    = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic [11:0] mouse_x_position, mouse_y_position;
  logic mouse_left, mouse_right, packet_valid, frame_err;

  int vec_cnt = 0;
  int err_cnt = 0;
  int pv_cnt = 0;
  int fe_cnt = 0;
  int both_seen = 0;
  int cyc = 0;

  int model_x, model_y;
  logic model_l, model_r;

  typedef struct {
    logic [7:0] b0, b1, b2;
    int pre;      // 0 none, 1 bad-parity byte first, 2 header without bit3 first
    int ex, ey;
    logic el, er;
    int efe;
  } vec_t;

  vec_t vecs[7];

  ps2_mouse_tracker #(
    .MAX_X(MAX_X), .MAX_Y(MAX_Y), .INIT_X(INIT_X), .INIT_Y(INIT_Y),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .mouse_x_position(mouse_x_position), .mouse_y_position(mouse_y_position),
    .mouse_left(mouse_left), .mouse_right(mouse_right),
    .packet_valid(packet_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (packet_valid) pv_cnt++;
    if (frame_err) fe_cnt++;
    if (packet_valid && frame_err) both_seen++;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2Bit(input logic b);
    ps2_data = b;
    waitCycles(HALF);
    ps2_clk = 1'b0;
    waitCycles(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic sendByte(input logic [7:0] d, input logic bad_parity);
    ps2Bit(1'b0);
    for (int i = 0; i < 8; i++) ps2Bit(d[i]);
    ps2Bit((~^d) ^ bad_parity);
    ps2Bit(1'b1);
    ps2_data = 1'b1;
    waitCycles(HALF);
  endtask

  function automatic int clampInt(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Reference model: PS/2 deltas are 9-bit signed, Y is up-positive on the wire
  task automatic modelPacket(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int dx, dy;
    dx = b0[4] ? int'(b1) - 256 : int'(b1);
    dy = b0[5] ? int'(b2) - 256 : int'(b2);
    if (b0[6]) dx = 0;
    if (b0[7]) dy = 0;
    model_x = clampInt(model_x + dx, MAX_X - 1);
    model_y = clampInt(model_y - dy, MAX_Y - 1);
    model_l = b0[0];
    model_r = b0[1];
  endtask

  task automatic modelReset();
    model_x = INIT_X;
    model_y = INIT_Y;
    model_l = 1'b0;
    model_r = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    sendByte(b0, 1'b0);
    sendByte(b1, 1'b0);
    sendByte(b2, 1'b0);
    waitCycles(4);
    modelPacket(b0, b1, b2);
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " x"}, int'(mouse_x_position), model_x);
    checkOutput({tag, " y"}, int'(mouse_y_position), model_y);
    checkOutput({tag, " left"}, int'(mouse_left), int'(model_l));
    checkOutput({tag, " right"}, int'(mouse_right), int'(model_r));
  endtask

  initial begin
    int pv0, fe0, fall_cyc, delta;
    logic [7:0] r0, r1, r2;

    vecs[0] = '{8'h09, 8'h0A, 8'h05, 0, 410, 295, 1'b1, 1'b0, 0};
    vecs[1] = '{8'h38, 8'h01, 8'h01, 0, 155, 550, 1'b0, 1'b0, 0};
    vecs[2] = '{8'h38, 8'h6A, 8'hD8, 0,   5, 590, 1'b0, 1'b0, 0};
    vecs[3] = '{8'h38, 8'hF0, 8'hE0, 0,   0, 599, 1'b0, 1'b0, 0};
    vecs[4] = '{8'h0A, 8'h01, 8'h00, 2,   1, 599, 1'b0, 1'b1, 0};
    vecs[5] = '{8'h09, 8'h0A, 8'h05, 1,  11, 594, 1'b1, 1'b0, 1};
    vecs[6] = '{8'h49, 8'hFF, 8'h03, 0,  11, 591, 1'b1, 1'b0, 0};

    modelReset();
    waitCycles(3);
    checkOutput("reset x", int'(mouse_x_position), INIT_X);
    checkOutput("reset y", int'(mouse_y_position), INIT_Y);
    checkOutput("reset left", int'(mouse_left), 0);
    checkOutput("reset right", int'(mouse_right), 0);
    checkOutput("reset pulses", int'(packet_valid) + int'(frame_err), 0);
    rst = 1'b0;
    waitCycles(5);

    $display("[TB] table-driven packets");
    foreach (vecs[i]) begin
      pv0 = pv_cnt;
      fe0 = fe_cnt;
      if (vecs[i].pre == 1) sendByte(vecs[i].b0, 1'b1);
      if (vecs[i].pre == 2) sendByte(8'h02, 1'b0);
      applyStimulus(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      checkOutput($sformatf("vec%0d x", i), int'(mouse_x_position), vecs[i].ex);
      checkOutput($sformatf("vec%0d y", i), int'(mouse_y_position), vecs[i].ey);
      checkOutput($sformatf("vec%0d left", i), int'(mouse_left), int'(vecs[i].el));
      checkOutput($sformatf("vec%0d right", i), int'(mouse_right), int'(vecs[i].er));
      checkOutput($sformatf("vec%0d packet_valid count", i), pv_cnt - pv0, 1);
      checkOutput($sformatf("vec%0d frame_err count", i), fe_cnt - fe0, vecs[i].efe);
    end

    $display("[TB] randomized packets");
    for (int n = 0; n < 24; n++) begin
      r0 = 8'($urandom_range(0, 255)) | 8'h08;
      r1 = 8'($urandom_range(0, 255));
      r2 = 8'($urandom_range(0, 255));
      pv0 = pv_cnt;
      applyStimulus(r0, r1, r2);
      checkModel($sformatf("rand%0d", n));
      checkOutput($sformatf("rand%0d packet_valid count", n), pv_cnt - pv0, 1);
    end

    $display("[TB] mid-frame timeout");
    pv0 = pv_cnt;
    fe0 = fe_cnt;
    ps2Bit(1'b0);
    ps2Bit(1'b1);
    ps2Bit(1'b0);
    ps2Bit(1'b1);
    ps2_data = 1'b0;
    waitCycles(HALF);
    ps2_clk = 1'b0;
    fall_cyc = cyc;
    waitCycles(HALF);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    delta = -1;
    for (int k = 0; k < TIMEOUT + 40; k++) begin
      @(negedge clk);
      if (frame_err && delta < 0) delta = cyc - fall_cyc;
    end
    checkOutput("timeout seen", int'(delta >= TIMEOUT && delta <= TIMEOUT + 6), 1);
    checkOutput("timeout frame_err count", fe_cnt - fe0, 1);
    checkOutput("timeout packet_valid count", pv_cnt - pv0, 0);
    checkModel("after timeout");
    applyStimulus(8'h09, 8'h03, 8'hFE);
    checkModel("post-timeout packet");

    $display("[TB] reset mid-frame");
    pv0 = pv_cnt;
    ps2Bit(1'b0);
    ps2Bit(1'b1);
    ps2Bit(1'b1);
    ps2_data = 1'b0;
    waitCycles(HALF);
    ps2_clk = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    modelReset();
    checkModel("async reset");
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    waitCycles(4);
    rst = 1'b0;
    waitCycles(4);
    checkOutput("reset pv count", pv_cnt - pv0, 0);
    applyStimulus(8'h1A, 8'hF6, 8'h07);
    checkModel("post-reset packet");

    checkOutput("pv/fe overlap", both_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
